// File: rtl/gsensor_ctrl_if.sv
// Start/done handshake between gsensor_ctrl (master) and the SPI serdes (slave).
interface gsensor_ctrl_if;
    logic        spi_start;
    logic [15:0] spi_data_tx;
    logic        spi_done;
    logic [7:0]  spi_data_rx;

    modport master (output spi_start, output spi_data_tx, input spi_done, input spi_data_rx);
    modport slave  (input spi_start, input spi_data_tx, output spi_done, output spi_data_rx);
endinterface

// File: rtl/gsensor_ctrl.sv
// G-sensor transaction sequencer: config writes, data-ready polling and axis reads via the serdes.
// Optional: define GSENSOR_DEVID_CHECK_EN to verify DEVID (0xE5) before configuring.
module gsensor_ctrl #(
    parameter int unsigned POLL_DIV   = 1000,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic           spi_clk,
    input  logic           reset,
    gsensor_ctrl_if.master spi,
    output logic [15:0]    accel_x,
    output logic [15:0]    accel_y,
    output logic [15:0]    accel_z,
    output logic           data_valid,
    output logic           init_done,
    output logic           id_err
);
    localparam int unsigned      CNT_W     = $clog2(GAP_CYCLES + POLL_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_RETRY = CNT_W'(GAP_CYCLES + POLL_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_GAP   = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [3:0] STEP_ID      = 4'd0;
    localparam logic [3:0] STEP_CFG0    = 4'd1;
    localparam logic [3:0] STEP_CFG1    = 4'd2;
    localparam logic [3:0] STEP_CFG2    = 4'd3;
    localparam logic [3:0] STEP_POLL    = 4'd4;
    localparam logic [3:0] STEP_AX0     = 4'd5;
    localparam logic [3:0] STEP_AX5     = 4'd10;
    localparam logic [3:0] STEP_PUBLISH = 4'd11;
`ifdef GSENSOR_DEVID_CHECK_EN
    localparam logic [3:0] STEP_FIRST   = STEP_ID;
`else
    localparam logic [3:0] STEP_FIRST   = STEP_CFG0;
`endif

    logic [1:0]       state, state_nxt;
    logic [3:0]       step, step_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             start_q, start_nxt;
    logic [15:0]      tx_q, tx_nxt;
    logic [5:0][7:0]  shadow, shadow_nxt;
    logic [15:0]      x_nxt, y_nxt, z_nxt;
    logic             dv_nxt, init_nxt, iderr_nxt;
    logic [2:0]       ax_idx;

    assign spi.spi_start   = start_q;
    assign spi.spi_data_tx = tx_q;
    assign ax_idx          = 3'(step - STEP_AX0);

    // SPI command word for each step: {R/W, MB=0, addr[5:0], wdata}
    function automatic logic [15:0] step_tx(input logic [3:0] s);
        case (s)
            STEP_ID:   step_tx = 16'h8000;
            STEP_CFG0: step_tx = 16'h2C0A;
            STEP_CFG1: step_tx = 16'h3108;
            STEP_CFG2: step_tx = 16'h2D08;
            STEP_POLL: step_tx = 16'hB000;
            default:   step_tx = {2'b10, 6'h32 + 6'(s - STEP_AX0), 8'h00};
        endcase
    endfunction

    always_ff @(posedge spi_clk) begin
        if (reset) begin
            state      <= ST_GAP;
            step       <= STEP_FIRST;
            cnt        <= CNT_GAP;
            start_q    <= 1'b0;
            tx_q       <= 16'h0000;
            shadow     <= '0;
            accel_x    <= 16'h0000;
            accel_y    <= 16'h0000;
            accel_z    <= 16'h0000;
            data_valid <= 1'b0;
            init_done  <= 1'b0;
            id_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            cnt        <= cnt_nxt;
            start_q    <= start_nxt;
            tx_q       <= tx_nxt;
            shadow     <= shadow_nxt;
            accel_x    <= x_nxt;
            accel_y    <= y_nxt;
            accel_z    <= z_nxt;
            data_valid <= dv_nxt;
            init_done  <= init_nxt;
            id_err     <= iderr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        step_nxt   = step;
        cnt_nxt    = cnt;
        start_nxt  = 1'b0;
        tx_nxt     = tx_q;
        shadow_nxt = shadow;
        x_nxt      = accel_x;
        y_nxt      = accel_y;
        z_nxt      = accel_z;
        dv_nxt     = 1'b0;
        init_nxt   = init_done;
        iderr_nxt  = id_err;
        case (state)
            ST_GAP: begin
                if (cnt > CNT_ONE) begin
                    cnt_nxt = cnt - CNT_ONE;
                end else if (step == STEP_PUBLISH) begin
                    // All three axes update on the same edge
                    x_nxt    = {shadow[1], shadow[0]};
                    y_nxt    = {shadow[3], shadow[2]};
                    z_nxt    = {shadow[5], shadow[4]};
                    dv_nxt   = 1'b1;
                    step_nxt = STEP_POLL;
                    cnt_nxt  = CNT_ONE;
                end else begin
                    state_nxt = ST_ISSUE;
                    start_nxt = 1'b1;
                    tx_nxt    = step_tx(step);
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (spi.spi_done) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = CNT_GAP;
                    case (step)
`ifdef GSENSOR_DEVID_CHECK_EN
                        STEP_ID: begin
                            if (spi.spi_data_rx == 8'hE5) begin
                                iderr_nxt = 1'b0;
                                step_nxt  = STEP_CFG0;
                            end else begin
                                iderr_nxt = 1'b1;
                                cnt_nxt   = CNT_RETRY;
                            end
                        end
`endif
                        STEP_CFG0: step_nxt = STEP_CFG1;
                        STEP_CFG1: step_nxt = STEP_CFG2;
                        STEP_CFG2: begin
                            step_nxt = STEP_POLL;
                            init_nxt = 1'b1;
                        end
                        STEP_POLL: begin
                            if (spi.spi_data_rx[7]) step_nxt = STEP_AX0;
                            else                    cnt_nxt  = CNT_RETRY;
                        end
                        default: begin
                            if (step >= STEP_AX0 && step <= STEP_AX5) begin
                                shadow_nxt[ax_idx] = spi.spi_data_rx;
                                step_nxt           = step + 4'd1;
                            end
                        end
                    endcase
                end
            end
            default: state_nxt = ST_GAP;
        endcase
    end
endmodule

// File: tb/tb_gsensor_ctrl.sv
// Self-checking bench for gsensor_ctrl: serdes responder plus transaction-level reference model.
module tb_gsensor_ctrl;
    localparam int GAP  = 3;
    localparam int PDIV = 5;
`ifdef GSENSOR_DEVID_CHECK_EN
    localparam logic [15:0] FIRST_TX      = 16'h8000;
    localparam int          EXP_ID_STARTS = 3;
    localparam int          EXP_ID_AFTER  = 1;
`else
    localparam logic [15:0] FIRST_TX      = 16'h2C0A;
    localparam int          EXP_ID_STARTS = 0;
    localparam int          EXP_ID_AFTER  = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        data_valid, init_done, id_err;

    gsensor_ctrl_if spi ();

    gsensor_ctrl #(.POLL_DIV(PDIV), .GAP_CYCLES(GAP)) dut (
        .spi_clk   (clk),
        .reset     (reset),
        .spi       (spi),
        .accel_x   (accel_x),
        .accel_y   (accel_y),
        .accel_z   (accel_z),
        .data_valid(data_valid),
        .init_done (init_done),
        .id_err    (id_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (transaction level)
    logic [15:0] exp_tx = FIRST_TX;
    int          exp_edge = 0;
    bit          exp_min = 1'b0;
    bit          busy = 1'b0;
    logic [15:0] cur_tx = 16'h0000;
    int          done_at = 0;
    logic [7:0]  ab [6];
    logic [15:0] m_x = 16'h0, m_y = 16'h0, m_z = 16'h0;
    logic [15:0] e_x = 16'h0, e_y = 16'h0, e_z = 16'h0;
    bit          m_init = 1'b0, m_iderr = 1'b0;
    int          exp_dv_cyc = -1;
    int          flag_chk_cyc = -1;
    int          dv_count = 0, n_id_starts = 0, n_cfg_starts = 0, n_poll_starts = 0;
    logic [7:0]  devid_q [$];
    logic [7:0]  poll_q [$];
    logic [7:0]  axis_q [$];
    int          lat_min = 18, lat_max = 18;
    bit          spur_en = 1'b0;

    // Serdes responder and model, all activity on the falling edge
    initial begin
        logic [7:0] rx;
        logic [2:0] ai;
        spi.spi_done    = 1'b0;
        spi.spi_data_rx = 8'h00;
        forever begin
            @(negedge clk);
            spi.spi_done = 1'b0;
            if (reset) begin
                busy         = 1'b0;
                exp_dv_cyc   = -1;
                flag_chk_cyc = -1;
                m_x = 16'h0; m_y = 16'h0; m_z = 16'h0;
                m_init = 1'b0; m_iderr = 1'b0;
                exp_tx   = FIRST_TX;
                exp_edge = cyc + 1 + GAP;
                exp_min  = 1'b0;
            end else begin
                if (cyc == flag_chk_cyc) begin
                    check("init_done_flag", 32'(init_done), 32'(m_init));
                    check("id_err_flag", 32'(id_err), 32'(m_iderr));
                end
                if (data_valid) begin
                    check("dv_time", 32'(cyc), 32'(exp_dv_cyc));
                    check("pub_x", 32'(accel_x), 32'(e_x));
                    check("pub_y", 32'(accel_y), 32'(e_y));
                    check("pub_z", 32'(accel_z), 32'(e_z));
                    m_x = e_x; m_y = e_y; m_z = e_z;
                    exp_dv_cyc = -1;
                    dv_count++;
                end else if (exp_dv_cyc >= 0 && cyc > exp_dv_cyc) begin
                    check("dv_missing", 32'(data_valid), 32'(1));
                    exp_dv_cyc = -1;
                end
                if (spi.spi_start) begin
                    if (busy) begin
                        check("start_while_busy", 32'(spi.spi_start), 32'(0));
                    end else begin
                        check("start_tx", 32'(spi.spi_data_tx), 32'(exp_tx));
                        if (exp_min) check("start_gap_min", 32'(cyc >= exp_edge), 32'(1));
                        else         check("start_time", 32'(cyc), 32'(exp_edge));
                        check("init_at_start", 32'(init_done), 32'(m_init));
                        check("iderr_at_start", 32'(id_err), 32'(m_iderr));
                        check("hold_x", 32'(accel_x), 32'(m_x));
                        check("hold_y", 32'(accel_y), 32'(m_y));
                        check("hold_z", 32'(accel_z), 32'(m_z));
                        busy    = 1'b1;
                        cur_tx  = spi.spi_data_tx;
                        done_at = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
                        if (cur_tx == 16'h8000) n_id_starts++;
                        if (cur_tx == 16'h2C0A || cur_tx == 16'h3108 || cur_tx == 16'h2D08) n_cfg_starts++;
                        if (cur_tx == 16'hB000) n_poll_starts++;
                    end
                end else if (busy && cyc == done_at) begin
                    check("tx_stable", 32'(spi.spi_data_tx), 32'(cur_tx));
                    if (cur_tx == 16'h8000)
                        rx = (devid_q.size() > 0) ? devid_q.pop_front() : 8'hE5;
                    else if (cur_tx == 16'hB000)
                        rx = (poll_q.size() > 0) ? poll_q.pop_front() :
                             (($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 127))
                                                          : (8'h80 | 8'($urandom_range(0, 127))));
                    else if (cur_tx[15:8] >= 8'hB2 && cur_tx[15:8] <= 8'hB7) begin
                        rx = (axis_q.size() > 0) ? axis_q.pop_front() : 8'($urandom);
                        ai = 3'(cur_tx[13:8] - 6'h32);
                        ab[ai] = rx;
                    end else
                        rx = 8'($urandom);
                    spi.spi_done    = 1'b1;
                    spi.spi_data_rx = rx;
                    busy     = 1'b0;
                    exp_min  = 1'b0;
                    exp_edge = cyc + 1 + GAP;
                    if (cur_tx == 16'h8000) begin
                        m_iderr = (rx != 8'hE5);
                        if (m_iderr) exp_edge = exp_edge + PDIV - 1;
                        else         exp_tx   = 16'h2C0A;
                        flag_chk_cyc = cyc + 1;
                    end else if (cur_tx == 16'h2C0A) exp_tx = 16'h3108;
                    else if (cur_tx == 16'h3108) exp_tx = 16'h2D08;
                    else if (cur_tx == 16'h2D08) begin
                        exp_tx = 16'hB000;
                        m_init = 1'b1;
                        flag_chk_cyc = cyc + 1;
                    end else if (cur_tx == 16'hB000) begin
                        if (rx[7]) exp_tx = 16'hB200;
                        else       exp_edge = exp_edge + PDIV - 1;
                    end else if (cur_tx == 16'hB700) begin
                        e_x = {ab[1], ab[0]};
                        e_y = {ab[3], ab[2]};
                        e_z = {ab[5], ab[4]};
                        exp_dv_cyc = cyc + 1 + GAP;
                        exp_tx  = 16'hB000;
                        exp_min = 1'b1;
                    end else
                        exp_tx = cur_tx + 16'h0100;
                end else if (!busy && spur_en && $urandom_range(0, 7) == 0) begin
                    spi.spi_done    = 1'b1;
                    spi.spi_data_rx = 8'($urandom);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_start"}, 32'(spi.spi_start), 32'(0));
        check({pfx, "_tx"}, 32'(spi.spi_data_tx), 32'(0));
        check({pfx, "_ax"}, 32'(accel_x), 32'(0));
        check({pfx, "_ay"}, 32'(accel_y), 32'(0));
        check({pfx, "_az"}, 32'(accel_z), 32'(0));
        check({pfx, "_dv"}, 32'(data_valid), 32'(0));
        check({pfx, "_init"}, 32'(init_done), 32'(0));
        check({pfx, "_iderr"}, 32'(id_err), 32'(0));
    endtask

    task automatic wait_dv(input int target, input int budget, input string tag);
        int n = 0;
        while (dv_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(dv_count >= target), 32'(1));
    endtask

    initial begin
        int n;
        int dv_base;
        reset = 1'b1;
`ifdef GSENSOR_DEVID_CHECK_EN
        devid_q.push_back(8'h00);
        devid_q.push_back(8'h00);
`endif
        poll_q.push_back(8'h00);
        poll_q.push_back(8'h80);
        axis_q.push_back(8'h34); axis_q.push_back(8'h12);
        axis_q.push_back(8'hFE); axis_q.push_back(8'hFF);
        axis_q.push_back(8'h00); axis_q.push_back(8'h01);
        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        #1 reset = 1'b0;

        // Scripted bring-up: ID retries, one not-ready poll, known sample
        wait_dv(1, 3000, "timeout_first_sample");
        check("sample1_x", 32'(accel_x), 32'h1234);
        check("sample1_y", 32'(accel_y), 32'hFFFE);
        check("sample1_z", 32'(accel_z), 32'h0100);
        check("id_starts", 32'(n_id_starts), 32'(EXP_ID_STARTS));
        check("cfg_starts", 32'(n_cfg_starts), 32'(3));
        check("poll_starts", 32'(n_poll_starts), 32'(2));
        check("init_level", 32'(init_done), 32'(1));

        // Randomised latency, poll results, axis data and spurious dones
        lat_min = 2;
        lat_max = 20;
        spur_en = 1'b1;
        wait_dv(6, 20000, "timeout_random_samples");

        // Reset in the middle of the 0x35 read
        n = 0;
        while (!(busy && cur_tx == 16'hB500) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("timeout_b500", 32'(busy && cur_tx == 16'hB500), 32'(1));
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_mid");
        n_id_starts  = 0;
        n_cfg_starts = 0;
        dv_base      = dv_count;
        @(posedge clk);
        #2 reset = 1'b0;
        wait_dv(dv_base + 1, 5000, "timeout_after_reset");
        check("id_after_reset", 32'(n_id_starts), 32'(EXP_ID_AFTER));
        check("cfg_after_reset", 32'(n_cfg_starts), 32'(3));
        check("init_after_reset", 32'(init_done), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gsensor_ctrl.md
# gsensor_ctrl

Transaction sequencer directly upstream of the SPI serializer/deserializer in the G-sensor path. After reset it optionally checks the accelerometer device ID, then writes the three configuration registers. It then polls the sensor's data-ready flag and reads the six axis bytes. It presents signed 16-bit X/Y/Z samples with a one-cycle valid strobe. All SPI traffic goes through the serdes start/done handshake; this block never touches SPI pins.

## Interface
- `POLL_DIV`, default 1000: spi_clk cycles between the end of a not-ready poll and the next poll (≥1).
- `GAP_CYCLES`, default 2: idle cycles between serdes `done` and the next `start` (≥1; guarantees CSN high gap).
- `spi_clk` in 1: sole clock, shared with serdes. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high; asserted together with serdes reset.
- `spi_start` out 1: one-cycle request to serdes.
- `spi_data_tx` out 16: {R/W, MB=0, addr[5:0], wdata[7:0]}; R/W=1 is read, wdata=0x00 on reads.
- `spi_done` in 1: one-cycle transaction complete from serdes.
- `spi_data_rx` in 8: read byte; valid in the `spi_done` cycle.
- `accel_x`, `accel_y`, `accel_z` out 16 each: latest sample, two's complement {DATAx1, DATAx0}.
- `data_valid` out 1: one-cycle pulse when all three axes update.
- `init_done` out 1: level; high once configuration writes complete.
- `id_err` out 1: level; high while the last DEVID read mismatched 0xE5.

## Operation
- Reset values: `spi_start`=0, `spi_data_tx`=0x0000, `accel_*`=0x0000, `data_valid`=0, `init_done`=0, `id_err`=0; FSM in GAP with the gap counter loaded to `GAP_CYCLES`.
- Transaction primitive: ISSUE (`spi_start`=1 for exactly one cycle, `spi_data_tx` driven) → WAIT_DONE (`spi_data_tx` held stable) → on `spi_done`, capture `spi_data_rx` for reads → GAP (`GAP_CYCLES` cycles) → next step.
- Main sequence steps:
  - ID: read 0x00 (tx 0x8000).
  - CFG0: write 0x2C←0x0A (tx 0x2C0A).
  - CFG1: write 0x31←0x08 (tx 0x3108).
  - CFG2: write 0x2D←0x08 (tx 0x2D08); `init_done` set when CFG2 completes.
  - POLL: read 0x30 (tx 0xB000). If rx[7]=1, go to AXES; else wait `POLL_DIV` cycles, then POLL again.
  - AXES: six single-byte reads, 0x32..0x37 (tx 0xB200..0xB700), into shadow bytes X0,X1,Y0,Y1,Z0,Z1.
  - PUBLISH: `accel_*` load from shadow in one edge, `data_valid`=1 that cycle, then return to POLL.
- Outputs never show a partially updated sample. `accel_*` hold their value between PUBLISH cycles.
- `spi_done` outside WAIT_DONE is ignored. `spi_data_rx` is sampled only in the WAIT_DONE cycle where `spi_done`=1.
- No timeout: WAIT_DONE waits indefinitely.
- Reset mid-transaction: `spi_start` drops at the reset edge, shadow bytes are discarded, the sequence restarts from the top, and `init_done`/`id_err` clear.

## Timing
- `spi_start` is asserted only after the GAP count expires. It is never asserted in the `spi_done` cycle or the cycle after it.
- The first `spi_start` after reset deasserts is at cycle `GAP_CYCLES`+1.
- Register write: `init_done` rises the cycle after CFG2's `spi_done`.
- `data_valid` rises `GAP_CYCLES`+1 cycles after the `spi_done` of the 0x37 read.
- Poll period when not ready: POLL `spi_done` + `GAP_CYCLES` + `POLL_DIV` cycles to the next `spi_start`.
- 16-bit result width: concatenation only; no sign extension or arithmetic (the sensor supplies sign-extended data).

## Configuration
- `GSENSOR_DEVID_CHECK_EN` defined: sequence starts at ID. If rx≠0xE5, `id_err`=1, wait `POLL_DIV` cycles, and retry ID; CFG is never reached until ID passes. If rx=0xE5, `id_err`=0 and proceed to CFG0.
- Not defined: ID step is absent, sequence starts at CFG0, and `id_err` is tied to 0.

## Test plan
- Reset release with the serdes model returning done 18 cycles after start → tx sequence 0x8000 (if EN), 0x2C0A, 0x3108, 0x2D08; one start pulse each; `init_done`=1 after the fourth done.
- DEVID returns 0x00 twice, then 0xE5 (EN defined) → `id_err` high after the first done, ID retried twice, `id_err` clears, then CFG0 is issued.
- POLL returns 0x00 → no AXES reads; the next 0xB000 is issued `GAP_CYCLES`+`POLL_DIV` cycles after done.
- POLL returns 0x80, axis bytes 0x34,0x12,0xFE,0xFF,0x00,0x01 → single `data_valid`; `accel_x`=0x1234, `accel_y`=0xFFFE, `accel_z`=0x0100.
- Reset asserted during the 0x35 read → all outputs return to reset values; previously published samples are cleared; the sequence restarts at the first step.
- Spurious `spi_done` during GAP/POLL_WAIT → no state change; `spi_start` spacing ≥ `GAP_CYCLES`+1 after every done throughout.
